// File: rtl/bitwise_logic_pipe_if.sv
// Handshake/operand/result bundle for bitwise_logic_pipe.
// The popcnt signal exists only when BWL_POPCNT_EN is defined.
interface bitwise_logic_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Y;
    logic             zero;
    logic             ones;
    logic             parity;
`ifdef BWL_POPCNT_EN
    logic [$clog2(WIDTH+1)-1:0] popcnt;
`endif

    modport master (
        output in_valid, op, A, B, out_ready,
        input  in_ready, out_valid, Y, zero, ones, parity
`ifdef BWL_POPCNT_EN
        , input popcnt
`endif
    );

    modport slave (
        input  in_valid, op, A, B, out_ready,
        output in_ready, out_valid, Y, zero, ones, parity
`ifdef BWL_POPCNT_EN
        , output popcnt
`endif
    );
endinterface

// File: rtl/bitwise_logic_pipe.sv
// Two-stage valid/ready bitwise logic unit with result status flags.
// Optional popcount output enabled by defining BWL_POPCNT_EN.
module bitwise_logic_pipe #(
    parameter int WIDTH = 8,
    parameter int PCW   = $clog2(WIDTH + 1)
) (
    input logic                 clk,
    input logic                 rst_n,
    bitwise_logic_pipe_if.slave bus
);

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_XNOR = 3'd3,
        OP_NAND = 3'd4,
        OP_NOR  = 3'd5,
        OP_NOTA = 3'd6,
        OP_ANDN = 3'd7
    } op_e;

    if (WIDTH < 1 || WIDTH > 64 || PCW != $clog2(WIDTH + 1)) begin : g_bad_cfg
        $error("bitwise_logic_pipe: WIDTH must be 1..64 and PCW must stay derived");
    end

    op_e              op_sel;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] r1;
    logic [WIDTH-1:0] y_q;
    logic             s1_valid;
    logic             s2_valid;
    logic             ready1;
    logic             ready2;
    logic             zero_q;
    logic             ones_q;
    logic             parity_q;

    assign op_sel = op_e'(bus.op);

    always_comb begin
        res = '0;
        unique case (op_sel)
            OP_AND:  res = bus.A & bus.B;
            OP_OR:   res = bus.A | bus.B;
            OP_XOR:  res = bus.A ^ bus.B;
            OP_XNOR: res = ~(bus.A ^ bus.B);
            OP_NAND: res = ~(bus.A & bus.B);
            OP_NOR:  res = ~(bus.A | bus.B);
            OP_NOTA: res = ~bus.A;
            OP_ANDN: res = bus.A & ~bus.B;
            default: res = '0;
        endcase
    end

    // Ready ripples backwards combinationally from out_ready; no skid buffer.
    assign ready2       = !s2_valid || bus.out_ready;
    assign ready1       = !s1_valid || ready2;
    assign bus.in_ready = ready1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            r1       <= '0;
        end else if (ready1) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r1 <= res;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            y_q      <= '0;
            zero_q   <= 1'b0;
            ones_q   <= 1'b0;
            parity_q <= 1'b0;
        end else if (ready2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                y_q      <= r1;
                zero_q   <= (r1 == '0);
                ones_q   <= (r1 == '1);
                parity_q <= ^r1;
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.Y         = y_q;
    assign bus.zero      = zero_q;
    assign bus.ones      = ones_q;
    assign bus.parity    = parity_q;

`ifdef BWL_POPCNT_EN
    logic [PCW-1:0] pc_d;
    logic [PCW-1:0] pc_q;

    always_comb begin
        pc_d = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            pc_d = pc_d + PCW'(r1[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
        end else if (ready2 && s1_valid) begin
            pc_q <= pc_d;
        end
    end

    assign bus.popcnt = pc_q;
`else
    // No popcount port: the remaining flags are produced exactly as above.
`endif

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Directed and randomized checks of bitwise_logic_pipe at WIDTH 8, 1 and 37
// against an operation-level reference model.
module tb_bitwise_logic_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int unsigned tests = 0;
    int unsigned fails = 0;

    bitwise_logic_pipe_if #(.WIDTH(8))  b8 ();
    bitwise_logic_pipe_if #(.WIDTH(1))  b1 ();
    bitwise_logic_pipe_if #(.WIDTH(37)) b37 ();

    bitwise_logic_pipe #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
    bitwise_logic_pipe #(.WIDTH(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
    bitwise_logic_pipe #(.WIDTH(37)) u_dut37 (.clk(clk), .rst_n(rst_n), .bus(b37.slave));

`ifdef BWL_POPCNT_EN
`define POPCNT(b) 64'(b.popcnt)
`else
`define POPCNT(b) 64'd0
`endif

    function automatic logic [63:0] mask_w(int w);
        return (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [63:0] model(int op, logic [63:0] a, logic [63:0] b, int w);
        logic [63:0] r;
        case (op)
            0:       r = a & b;
            1:       r = a | b;
            2:       r = a ^ b;
            3:       r = ~(a ^ b);
            4:       r = ~(a & b);
            5:       r = ~(a | b);
            6:       r = ~a;
            default: r = a & ~b;
        endcase
        return r & mask_w(w);
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_res(string tag, int w, logic ov, logic [63:0] y, logic z, logic o,
                           logic p, logic [63:0] pc, logic [63:0] ey);
        check({tag, ".valid"},  64'(ov), 64'd1);
        check({tag, ".Y"},      y, ey);
        check({tag, ".zero"},   64'(z), 64'(ey == 64'd0));
        check({tag, ".ones"},   64'(o), 64'(ey == mask_w(w)));
        check({tag, ".parity"}, 64'(p), 64'($countones(ey) % 2));
`ifdef BWL_POPCNT_EN
        check({tag, ".popcnt"}, pc, 64'($countones(ey)));
`else
        if (pc != 64'd0) check({tag, ".popcnt_absent"}, pc, 64'd0);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic single8(int op, logic [7:0] a, logic [7:0] b, logic [7:0] ey, string tag);
        b8.op = 3'(op); b8.A = a; b8.B = b; b8.in_valid = 1'b1; b8.out_ready = 1'b1;
        #1;
        check({tag, ".in_ready"}, 64'(b8.in_ready), 64'd1);
        step();
        b8.in_valid = 1'b0;
        check({tag, ".not_yet"}, 64'(b8.out_valid), 64'd0);
        step();
        chk_res(tag, 8, b8.out_valid, 64'(b8.Y), b8.zero, b8.ones, b8.parity, `POPCNT(b8), 64'(ey));
        step();
        check({tag, ".drained"}, 64'(b8.out_valid), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] q8[$], q1[$], q37[$];
        logic [63:0] ea, eb;
        logic [7:0]  bp_y[3];
        int          opv;

        b8.in_valid = 0;  b8.op = 0;  b8.A = 0;  b8.B = 0;  b8.out_ready = 1;
        b1.in_valid = 0;  b1.op = 0;  b1.A = 0;  b1.B = 0;  b1.out_ready = 1;
        b37.in_valid = 0; b37.op = 0; b37.A = 0; b37.B = 0; b37.out_ready = 1;

        // Reset before any clock edge
        rst_n = 1'b0;
        #1;
        check("rst.out_valid", 64'(b8.out_valid), 64'd0);
        check("rst.Y",         64'(b8.Y),         64'd0);
        check("rst.zero",      64'(b8.zero),      64'd0);
        check("rst.ones",      64'(b8.ones),      64'd0);
        check("rst.parity",    64'(b8.parity),    64'd0);
        check("rst.in_ready",  64'(b8.in_ready),  64'd1);
        check("rst.Y37",       64'(b37.Y),        64'd0);
`ifdef BWL_POPCNT_EN
        check("rst.popcnt",    `POPCNT(b8),       64'd0);
`endif
        step();
        step();
        check("rst_hold.in_ready", 64'(b8.in_ready), 64'd1);
        rst_n = 1'b1;
        step();
        step();
        check("idle.out_valid", 64'(b8.out_valid), 64'd0);
        check("idle.in_ready",  64'(b8.in_ready),  64'd1);
        check("idle.out_valid1", 64'(b1.out_valid), 64'd0);

        // Directed opcodes and flag extremes
        single8(3, 8'hF0, 8'hCC, 8'hC3, "xnor");
        single8(2, 8'h5A, 8'h5A, 8'h00, "xor_zero");
        single8(5, 8'h00, 8'h00, 8'hFF, "nor_ones");
        single8(7, 8'h07, 8'h02, 8'h05, "andn");
        single8(6, 8'h3C, 8'hA5, 8'hC3, "not_a");
        single8(4, 8'hFF, 8'h0F, 8'hF0, "nand");

        // Backpressure: two accepted, third refused while Y holds
        b8.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            opv = int'($urandom_range(0, 7));
            ea = 64'($urandom); eb = 64'($urandom);
            b8.op = 3'(opv); b8.A = ea[7:0]; b8.B = eb[7:0]; b8.in_valid = 1'b1;
            bp_y[i] = 8'(model(opv, ea, eb, 8));
            #1;
            if (i < 2) begin
                check($sformatf("bp.accept%0d", i), 64'(b8.in_ready), 64'd1);
                step();
            end
        end
        check("bp.full_ready", 64'(b8.in_ready), 64'd0);
        chk_res("bp.hold0", 8, b8.out_valid, 64'(b8.Y), b8.zero, b8.ones, b8.parity, `POPCNT(b8), 64'(bp_y[0]));
        step();
        check("bp.full_ready2", 64'(b8.in_ready), 64'd0);
        chk_res("bp.hold1", 8, b8.out_valid, 64'(b8.Y), b8.zero, b8.ones, b8.parity, `POPCNT(b8), 64'(bp_y[0]));
        b8.out_ready = 1'b1;
        #1;
        check("bp.release_ready", 64'(b8.in_ready), 64'd1);
        chk_res("bp.out0", 8, b8.out_valid, 64'(b8.Y), b8.zero, b8.ones, b8.parity, `POPCNT(b8), 64'(bp_y[0]));
        step();
        b8.in_valid = 1'b0;
        chk_res("bp.out1", 8, b8.out_valid, 64'(b8.Y), b8.zero, b8.ones, b8.parity, `POPCNT(b8), 64'(bp_y[1]));
        step();
        chk_res("bp.out2", 8, b8.out_valid, 64'(b8.Y), b8.zero, b8.ones, b8.parity, `POPCNT(b8), 64'(bp_y[2]));
        step();
        check("bp.drained", 64'(b8.out_valid), 64'd0);

        // Streaming: 16 random back-to-back transactions on all three widths
        for (int k = 0; k <= 16; k++) begin
            if (k < 16) begin
                opv = int'($urandom_range(0, 7)); ea = {$urandom, $urandom}; eb = {$urandom, $urandom};
                b8.op = 3'(opv); b8.A = ea[7:0]; b8.B = eb[7:0]; b8.in_valid = 1'b1;
                q8.push_back(model(opv, ea, eb, 8));
                opv = int'($urandom_range(0, 7)); ea = {$urandom, $urandom}; eb = {$urandom, $urandom};
                b1.op = 3'(opv); b1.A = ea[0:0]; b1.B = eb[0:0]; b1.in_valid = 1'b1;
                q1.push_back(model(opv, ea, eb, 1));
                opv = int'($urandom_range(0, 7)); ea = {$urandom, $urandom}; eb = {$urandom, $urandom};
                b37.op = 3'(opv); b37.A = ea[36:0]; b37.B = eb[36:0]; b37.in_valid = 1'b1;
                q37.push_back(model(opv, ea, eb, 37));
                #1;
                check($sformatf("s8_%0d.in_ready", k),  64'(b8.in_ready),  64'd1);
                check($sformatf("s1_%0d.in_ready", k),  64'(b1.in_ready),  64'd1);
                check($sformatf("s37_%0d.in_ready", k), 64'(b37.in_ready), 64'd1);
            end else begin
                b8.in_valid = 1'b0; b1.in_valid = 1'b0; b37.in_valid = 1'b0;
            end
            step();
            if (k >= 1) begin
                chk_res($sformatf("s8_%0d", k - 1), 8, b8.out_valid, 64'(b8.Y), b8.zero, b8.ones,
                        b8.parity, `POPCNT(b8), q8.pop_front());
                chk_res($sformatf("s1_%0d", k - 1), 1, b1.out_valid, 64'(b1.Y), b1.zero, b1.ones,
                        b1.parity, `POPCNT(b1), q1.pop_front());
                chk_res($sformatf("s37_%0d", k - 1), 37, b37.out_valid, 64'(b37.Y), b37.zero, b37.ones,
                        b37.parity, `POPCNT(b37), q37.pop_front());
            end
        end
        step();
        check("stream.end8",  64'(b8.out_valid),  64'd0);
        check("stream.end1",  64'(b1.out_valid),  64'd0);
        check("stream.end37", 64'(b37.out_valid), 64'd0);

        // Asynchronous reset with two transactions in flight
        b8.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            b8.op = 3'd1; b8.A = 8'(8'h11 << i); b8.B = 8'h80; b8.in_valid = 1'b1;
            #1;
            check($sformatf("ar.accept%0d", i), 64'(b8.in_ready), 64'd1);
            step();
        end
        b8.in_valid = 1'b0;
        check("ar.full", 64'(b8.out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar.out_valid", 64'(b8.out_valid), 64'd0);
        check("ar.Y",         64'(b8.Y),         64'd0);
        check("ar.parity",    64'(b8.parity),    64'd0);
        check("ar.in_ready",  64'(b8.in_ready),  64'd1);
        step();
        rst_n = 1'b1;
        b8.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("ar.no_stale%0d", i), 64'(b8.out_valid), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
